// File: rtl/br_cam_table.sv
// BrLite broadcast packet table: filters duplicate {producer,id} keys and replays
// each stored packet once per requested output port, retiring entries by CLEAR or ageing.
package br_cam_pkg;
   typedef enum logic [1:0] {
      BR_SVC_ALL   = 2'd0,
      BR_SVC_TGT   = 2'd1,
      BR_SVC_MON   = 2'd2,
      BR_SVC_CLEAR = 2'd3
   } br_svc_t;
endpackage

module br_cam_table
   import br_cam_pkg::*;
#(
   parameter int unsigned CAM_SIZE   = 8,
   parameter int unsigned NPORT      = 5,
   parameter int unsigned PAYLOAD_W  = 32,
   parameter int unsigned PRODUCER_W = 16,
   parameter int unsigned ID_W       = 5,
   parameter int unsigned AGE_MAX    = 255,
   localparam int unsigned PORT_W    = (NPORT > 1) ? $clog2(NPORT) : 1,
   localparam int unsigned OCC_W     = $clog2(CAM_SIZE + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  br_svc_t               in_svc_i,
   input  logic [PRODUCER_W-1:0] in_producer_i,
   input  logic [ID_W-1:0]       in_id_i,
   input  logic [PAYLOAD_W-1:0]  in_payload_i,
   input  logic [NPORT-1:0]      in_fwd_mask_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [PORT_W-1:0]     out_port_o,
   output br_svc_t               out_svc_o,
   output logic [PRODUCER_W-1:0] out_producer_o,
   output logic [ID_W-1:0]       out_id_o,
   output logic [PAYLOAD_W-1:0]  out_payload_o,
   output logic                  dup_o,
   output logic                  full_o,
   output logic [OCC_W-1:0]      occupancy_o
);
   localparam int unsigned IDX_W = $clog2(CAM_SIZE);
   localparam int unsigned AGE_W = $clog2(AGE_MAX + 1);

   logic [CAM_SIZE-1:0]   valid;
   logic [CAM_SIZE-1:0]   clr;
   br_svc_t               svc      [CAM_SIZE];
   logic [PRODUCER_W-1:0] producer [CAM_SIZE];
   logic [ID_W-1:0]       id       [CAM_SIZE];
   logic [PAYLOAD_W-1:0]  payload  [CAM_SIZE];
   logic [NPORT-1:0]      pending  [CAM_SIZE];
   logic [AGE_W-1:0]      age      [CAM_SIZE];
   logic [IDX_W-1:0]      rr_ptr;
   logic [IDX_W-1:0]      out_idx;

   logic                  accept, hs, load;
   logic                  hit_any, free_any, do_alloc, do_replace, do_dup;
   logic [IDX_W-1:0]      hit_idx, free_idx;
   logic [NPORT-1:0]      hs_bit;
   logic                  sel_found, port_found;
   logic [IDX_W-1:0]      sel_idx, scan_idx;
   logic [NPORT-1:0]      sel_pend, cand;
   logic [PORT_W-1:0]     sel_port;
   int unsigned           scan;
   logic [OCC_W-1:0]      occ;

   assign full_o      = &valid;
   assign occupancy_o = occ;
   assign in_ready_o  = ~full_o & ~rst_i;
   assign accept      = in_valid_i & in_ready_o;
   assign hs          = out_valid_o & out_ready_i;
   assign load        = ~out_valid_o | out_ready_i;
   assign hs_bit      = hs ? (NPORT'(1) << out_port_o) : '0;

   always_comb begin
      occ = '0;
      for (int unsigned i = 0; i < CAM_SIZE; i++) begin
         occ = occ + OCC_W'(valid[i]);
      end
   end

   always_comb begin
      hit_any  = 1'b0;
      hit_idx  = '0;
      free_any = 1'b0;
      free_idx = '0;
      for (int unsigned i = 0; i < CAM_SIZE; i++) begin
         if (valid[i] && producer[i] == in_producer_i && id[i] == in_id_i) begin
            hit_any = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!valid[i] && !free_any) begin
            free_any = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   assign do_alloc   = accept & ~hit_any & (in_svc_i != BR_SVC_CLEAR) & free_any;
   assign do_replace = accept & hit_any & (in_svc_i == BR_SVC_CLEAR) & (svc[hit_idx] != BR_SVC_CLEAR);
   assign do_dup     = accept & hit_any & ~do_replace;

   // Round-robin scan from rr_ptr; the (entry,port) finishing its handshake is masked out.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_pend  = '0;
      scan      = 0;
      scan_idx  = '0;
      cand      = '0;
      for (int unsigned k = 0; k < CAM_SIZE; k++) begin
         scan = k + 32'(rr_ptr);
         if (scan >= CAM_SIZE) scan = scan - CAM_SIZE;
         scan_idx = IDX_W'(scan);
         cand = pending[scan_idx];
         if (scan_idx == out_idx) cand = cand & ~hs_bit;
         if (!sel_found && valid[scan_idx] && cand != '0) begin
            sel_found = 1'b1;
            sel_idx   = scan_idx;
            sel_pend  = cand;
         end
      end
   end

   always_comb begin
      sel_port   = '0;
      port_found = 1'b0;
      for (int unsigned p = 0; p < NPORT; p++) begin
         if (sel_pend[p] && !port_found) begin
            port_found = 1'b1;
            sel_port   = PORT_W'(p);
         end
      end
   end

   // An insert write to an entry takes priority over its handshake clear and over retirement.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid <= '0;
         clr   <= '0;
         for (int unsigned i = 0; i < CAM_SIZE; i++) begin
            svc[i]      <= BR_SVC_ALL;
            producer[i] <= '0;
            id[i]       <= '0;
            payload[i]  <= '0;
            pending[i]  <= '0;
            age[i]      <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < CAM_SIZE; i++) begin
            if (do_alloc && free_idx == IDX_W'(i)) begin
               valid[i]    <= 1'b1;
               svc[i]      <= in_svc_i;
               producer[i] <= in_producer_i;
               id[i]       <= in_id_i;
               payload[i]  <= in_payload_i;
               pending[i]  <= in_fwd_mask_i;
               clr[i]      <= 1'b0;
               age[i]      <= '0;
            end else if (do_replace && hit_idx == IDX_W'(i)) begin
               svc[i]     <= BR_SVC_CLEAR;
               pending[i] <= in_fwd_mask_i;
               clr[i]     <= 1'b1;
               age[i]     <= '0;
            end else if (valid[i]) begin
               if (pending[i] == '0) begin
                  if (clr[i] || age[i] == AGE_W'(AGE_MAX)) begin
                     valid[i] <= 1'b0;
                     clr[i]   <= 1'b0;
                     age[i]   <= '0;
                  end else begin
                     age[i] <= age[i] + 1'b1;
                  end
               end else if (out_idx == IDX_W'(i)) begin
                  pending[i] <= pending[i] & ~hs_bit;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_o    <= 1'b0;
         out_port_o     <= '0;
         out_svc_o      <= BR_SVC_ALL;
         out_producer_o <= '0;
         out_id_o       <= '0;
         out_payload_o  <= '0;
         out_idx        <= '0;
         rr_ptr         <= '0;
         dup_o          <= 1'b0;
      end else begin
         dup_o <= do_dup;
         if (load) begin
            out_valid_o <= sel_found;
            if (sel_found) begin
               out_idx        <= sel_idx;
               out_port_o     <= sel_port;
               out_svc_o      <= svc[sel_idx];
               out_producer_o <= producer[sel_idx];
               out_id_o       <= id[sel_idx];
               out_payload_o  <= payload[sel_idx];
               rr_ptr         <= (sel_idx == IDX_W'(CAM_SIZE - 1)) ? '0 : sel_idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_br_cam_table.sv
// Bench for br_cam_table: directed scenarios plus random traffic against an
// array-based reference model of the table.
module tb_br_cam_table;
   import br_cam_pkg::*;

   localparam int CS = 8;
   localparam int NP = 5;
   localparam int AM = 40;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   br_svc_t       in_svc;
   logic [15:0]   in_producer;
   logic [4:0]    in_id;
   logic [31:0]   in_payload;
   logic [NP-1:0] in_fwd_mask;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    out_port;
   br_svc_t       out_svc;
   logic [15:0]   out_producer;
   logic [4:0]    out_id;
   logic [31:0]   out_payload;
   logic          dup;
   logic          full;
   logic [3:0]    occupancy;

   initial forever #5 clk = ~clk;

   br_cam_table #(
      .CAM_SIZE(CS), .NPORT(NP), .PAYLOAD_W(32), .PRODUCER_W(16), .ID_W(5), .AGE_MAX(AM)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_svc_i(in_svc),
      .in_producer_i(in_producer), .in_id_i(in_id), .in_payload_i(in_payload),
      .in_fwd_mask_i(in_fwd_mask),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_port_o(out_port),
      .out_svc_o(out_svc), .out_producer_o(out_producer), .out_id_o(out_id),
      .out_payload_o(out_payload),
      .dup_o(dup), .full_o(full), .occupancy_o(occupancy)
   );

   typedef struct {
      bit            valid;
      br_svc_t       svc;
      logic [15:0]   prod;
      logic [4:0]    id;
      logic [31:0]   pay;
      logic [NP-1:0] pend;
      bit            clr;
      int            age;
   } ent_t;

   typedef struct {
      int          port;
      br_svc_t     svc;
      logic [31:0] pay;
   } beat_t;

   ent_t        m [CS];
   int          m_rr, m_oidx, m_oport;
   bit          m_ov, m_dup;
   br_svc_t     m_osvc;
   logic [15:0] m_oprod;
   logic [4:0]  m_oid;
   logic [31:0] m_opay;
   beat_t       beats[$];
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int m_occ();
      int c = 0;
      for (int e = 0; e < CS; e++) if (m[e].valid) c++;
      return c;
   endfunction

   task automatic model_step();
      ent_t          nx [CS];
      int            occ, hit, fre, sel, sport, wr, hs_idx, hs_port;
      bit            hs;
      logic [NP-1:0] cand;
      if (rst) begin
         for (int e = 0; e < CS; e++) begin
            m[e].valid = 0; m[e].pend = '0; m[e].clr = 0; m[e].age = 0;
         end
         m_rr = 0; m_ov = 0; m_oidx = 0; m_oport = 0; m_osvc = BR_SVC_ALL;
         m_oprod = '0; m_oid = '0; m_opay = '0; m_dup = 0;
         return;
      end
      nx = m;
      occ = m_occ();
      hs = m_ov && out_ready;
      hs_idx = m_oidx;
      hs_port = m_oport;
      if (!m_ov || out_ready) begin
         sel = -1;
         sport = 0;
         for (int k = 0; k < CS; k++) begin
            int e = (m_rr + k) % CS;
            cand = m[e].pend;
            if (hs && e == hs_idx) cand[hs_port] = 1'b0;
            if (sel < 0 && m[e].valid && cand != '0) begin
               sel = e;
               for (int p = NP - 1; p >= 0; p--) if (cand[p]) sport = p;
            end
         end
         m_ov = (sel >= 0);
         if (sel >= 0) begin
            m_oidx = sel; m_oport = sport; m_osvc = m[sel].svc;
            m_oprod = m[sel].prod; m_oid = m[sel].id; m_opay = m[sel].pay;
            m_rr = (sel + 1) % CS;
         end
      end
      m_dup = 0;
      wr = -1;
      if (in_valid && occ < CS) begin
         hit = -1;
         fre = -1;
         for (int e = 0; e < CS; e++)
            if (m[e].valid && m[e].prod == in_producer && m[e].id == in_id) hit = e;
         for (int e = CS - 1; e >= 0; e--) if (!m[e].valid) fre = e;
         if (hit < 0) begin
            if (in_svc != BR_SVC_CLEAR) begin
               wr = fre;
               nx[fre].valid = 1; nx[fre].svc = in_svc; nx[fre].prod = in_producer;
               nx[fre].id = in_id; nx[fre].pay = in_payload; nx[fre].pend = in_fwd_mask;
               nx[fre].clr = 0; nx[fre].age = 0;
            end
         end else if (in_svc == BR_SVC_CLEAR && m[hit].svc != BR_SVC_CLEAR) begin
            wr = hit;
            nx[hit].svc = BR_SVC_CLEAR; nx[hit].pend = in_fwd_mask;
            nx[hit].clr = 1; nx[hit].age = 0;
         end else begin
            m_dup = 1;
         end
      end
      for (int e = 0; e < CS; e++) begin
         if (e != wr && m[e].valid) begin
            if (m[e].pend == '0) begin
               if (m[e].clr || m[e].age == AM) begin
                  nx[e].valid = 0; nx[e].clr = 0; nx[e].age = 0;
               end else begin
                  nx[e].age = m[e].age + 1;
               end
            end else if (hs && e == hs_idx) begin
               nx[e].pend[hs_port] = 1'b0;
            end
         end
      end
      m = nx;
   endtask

   task automatic compare_all();
      check("in_ready", in_ready, !rst && m_occ() < CS);
      check("full", full, m_occ() == CS);
      check("occupancy", occupancy, m_occ());
      check("dup", dup, m_dup);
      check("out_valid", out_valid, m_ov);
      if (m_ov) begin
         check("out_port", out_port, m_oport);
         check("out_svc", out_svc, m_osvc);
         check("out_producer", out_producer, m_oprod);
         check("out_id", out_id, m_oid);
         check("out_payload", out_payload, m_opay);
      end
   endtask

   task automatic tick();
      if (out_valid && out_ready && !rst) begin
         beat_t b;
         b.port = int'(out_port); b.svc = out_svc; b.pay = out_payload;
         beats.push_back(b);
      end
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic put(input br_svc_t s, input logic [15:0] p, input logic [4:0] i,
                      input logic [31:0] pay, input logic [NP-1:0] mask);
      in_valid = 1'b1; in_svc = s; in_producer = p; in_id = i;
      in_payload = pay; in_fwd_mask = mask;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      beats.delete();
   endtask

   initial begin
      int waited;
      rst = 1'b1; in_valid = 1'b0; in_svc = BR_SVC_ALL; in_producer = '0; in_id = '0;
      in_payload = '0; in_fwd_mask = '0; out_ready = 1'b0;
      tick();
      tick();
      check("rst_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_payload", out_payload, 32'h0);
      check("rst_out_port", out_port, 3'd0);
      check("rst_occupancy", occupancy, 4'd0);
      rst = 1'b0;
      beats.delete();

      // 1: two-port broadcast
      out_ready = 1'b1;
      put(BR_SVC_ALL, 16'h0102, 5'd3, 32'hCAFE_0001, 5'b00101);
      repeat (5) tick();
      check("t1_beats", beats.size(), 2);
      if (beats.size() == 2) begin
         check("t1_port0", beats[0].port, 0);
         check("t1_port1", beats[1].port, 2);
         check("t1_pay", beats[1].pay, 32'hCAFE_0001);
      end
      check("t1_occ", occupancy, 4'd1);
      beats.delete();

      // 2: duplicate
      put(BR_SVC_ALL, 16'h0102, 5'd3, 32'hDEAD_0002, 5'b11111);
      check("t2_dup", dup, 1'b1);
      tick();
      check("t2_dup_clr", dup, 1'b0);
      repeat (3) tick();
      check("t2_beats", beats.size(), 0);
      check("t2_occ", occupancy, 4'd1);

      // 3: CLEAR replace, then CLEAR miss
      put(BR_SVC_CLEAR, 16'h0102, 5'd3, 32'h0, 5'b00010);
      repeat (5) tick();
      check("t3_beats", beats.size(), 1);
      if (beats.size() == 1) begin
         check("t3_port", beats[0].port, 1);
         check("t3_svc", beats[0].svc, BR_SVC_CLEAR);
         check("t3_pay", beats[0].pay, 32'hCAFE_0001);
      end
      check("t3_occ", occupancy, 4'd0);
      put(BR_SVC_CLEAR, 16'h0102, 5'd3, 32'h0, 5'b00010);
      check("t3_nodup", dup, 1'b0);
      check("t3_occ2", occupancy, 4'd0);
      beats.delete();

      // 4: fill with filter-only entries, then age out
      for (int k = 0; k < CS; k++) put(BR_SVC_TGT, 16'h0100 + 16'(k), 5'd1, 32'(k), '0);
      check("t4_full", full, 1'b1);
      check("t4_ready", in_ready, 1'b0);
      check("t4_occ", occupancy, 4'd8);
      repeat (AM + 1) tick();
      check("t4_aged", occupancy, 4'd0);

      // 5: back-pressure then round-robin release
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) put(BR_SVC_MON, 16'h0200, 5'(k), 32'hA000 + 32'(k), 5'b00001);
      for (int k = 0; k < 10; k++) begin
         tick();
         check("t5_hold_valid", out_valid, 1'b1);
         check("t5_hold_pay", out_payload, 32'hA000);
      end
      out_ready = 1'b1;
      repeat (6) tick();
      check("t5_beats", beats.size(), 3);
      for (int k = 0; k < beats.size() && k < 3; k++) check("t5_order", beats[k].pay, 32'hA000 + 32'(k));

      // 6: CLEAR lands on the handshake cycle of the presented entry
      do_reset();
      out_ready = 1'b0;
      put(BR_SVC_ALL, 16'h0300, 5'd7, 32'hBEEF_0006, 5'b00001);
      waited = 0;
      while (!out_valid && waited < 10) begin
         tick();
         waited++;
      end
      check("t6_present", out_valid, 1'b1);
      out_ready = 1'b1;
      put(BR_SVC_CLEAR, 16'h0300, 5'd7, 32'h0, 5'b00001);
      repeat (6) tick();
      check("t6_beats", beats.size(), 2);
      if (beats.size() == 2) begin
         check("t6_svc", beats[1].svc, BR_SVC_CLEAR);
         check("t6_port", beats[1].port, 0);
      end
      check("t6_occ", occupancy, 4'd0);

      // random traffic against the model
      do_reset();
      for (int k = 0; k < 2500; k++) begin
         rst = (k == 1200);
         in_valid = ($urandom_range(0, 1) == 1);
         in_svc = br_svc_t'($urandom_range(0, 3));
         in_producer = 16'($urandom_range(0, 3));
         in_id = 5'($urandom_range(0, 3));
         in_payload = $urandom;
         in_fwd_mask = NP'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      rst = 1'b0;
      in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
